// File: rtl/asi_ram.sv
// Single-port byte-writable RAM behind the ASI user port.
// Writes commit on the accepting edge; reads respond after RAM_WS wait states.
module asi_ram_lane #(
  parameter int SZ = 512,
  parameter int AW = 9,
  parameter int BW = 8
) (
  input  logic          ACLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);
  logic [BW-1:0] mem [SZ];

  always_ff @(posedge ACLK)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module asi_ram #(
  parameter int RAM_SZ = 512,
  parameter int RAM_BW = 8,
  parameter int RAM_BS = 4,
  parameter int RAM_WS = 1,
  parameter int RAM_AW = $clog2(RAM_SZ),
  parameter int RAM_DW = RAM_BW * RAM_BS
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              usr_req,
  output logic              usr_gnt,
  input  logic              usr_we,
  input  logic [RAM_AW-1:0] usr_addr,
  input  logic [RAM_BS-1:0] usr_be,
  input  logic [RAM_DW-1:0] usr_wdata,
  output logic              usr_rvalid,
  input  logic              usr_rready,
  output logic [RAM_DW-1:0] usr_rdata
);
  if (RAM_WS < 0 || RAM_WS > 15) begin : g_ws_bad
    $fatal(1, "asi_ram: RAM_WS must be within 0..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [RAM_AW:0] SZ_W  = (RAM_AW + 1)'(RAM_SZ);
  localparam logic [3:0]      WS_M1 = (RAM_WS == 0) ? 4'd0 : 4'(RAM_WS - 1);

  state_t state, state_nxt;
  logic [3:0]                    cnt;
  logic [RAM_AW-1:0]             raddr;
  logic [RAM_AW-1:0]             rd_sel;
  logic                          acc, rd_acc, wr_en, load;
  logic [RAM_BS-1:0]             lane_we;
  logic [RAM_BS-1:0][RAM_BW-1:0] lane_q;
  logic [RAM_DW-1:0]             rd_word;

  assign acc     = usr_req && (state == IDLE);
  assign rd_acc  = acc && !usr_we;
  assign wr_en   = acc && usr_we && ({1'b0, usr_addr} < SZ_W);
  assign lane_we = {RAM_BS{wr_en}} & usr_be;

  // In IDLE the incoming address feeds the array directly so WS=0 reads load in one edge.
  assign rd_sel  = (state == IDLE) ? usr_addr : raddr;
  assign rd_word = ({1'b0, rd_sel} < SZ_W) ? RAM_DW'(lane_q) : '0;
  assign load    = (rd_acc && RAM_WS == 0) || (state == WAIT && cnt == 4'd0);

  asi_ram_lane #(.SZ(RAM_SZ), .AW(RAM_AW), .BW(RAM_BW)) u_lane [RAM_BS-1:0] (
    .ACLK  (ACLK),
    .we    (lane_we),
    .waddr (usr_addr),
    .wdata (usr_wdata),
    .raddr (rd_sel),
    .rdata (lane_q)
  );

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (usr_req && !usr_we) state_nxt = (RAM_WS == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (usr_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    usr_gnt    = (state == IDLE);
    usr_rvalid = (state == RESP);
  end

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      cnt       <= 4'd0;
      raddr     <= '0;
      usr_rdata <= '0;
    end else begin
      if (rd_acc) begin
        raddr <= usr_addr;
        cnt   <= WS_M1;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (load) usr_rdata <= rd_word;
    end
endmodule

// File: tb/tb_asi_ram.sv
// Bench for asi_ram: directed cases plus randomized traffic against a word-array model.
// A second instance with three wait states covers reset during a pending read.
module tb_asi_ram;
  localparam int SZ_A = 500;
  localparam int WS_A = 1;
  localparam int WS_B = 3;

  logic        clk = 1'b0;
  logic        rst_n, req, gnt, we, rvalid, rready;
  logic [8:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata, rdata;

  logic        b_rst_n, b_req, b_gnt, b_we, b_rvalid, b_rready;
  logic [8:0]  b_addr;
  logic [3:0]  b_be;
  logic [31:0] b_wdata, b_rdata;

  int ncmp = 0;
  int nerr = 0;
  logic [31:0] model [SZ_A];

  always #5 clk = ~clk;

  asi_ram #(.RAM_SZ(SZ_A), .RAM_BW(8), .RAM_BS(4), .RAM_WS(WS_A)) dut (
    .ACLK(clk), .ARESETn(rst_n), .usr_req(req), .usr_gnt(gnt), .usr_we(we),
    .usr_addr(addr), .usr_be(be), .usr_wdata(wdata), .usr_rvalid(rvalid),
    .usr_rready(rready), .usr_rdata(rdata)
  );

  asi_ram #(.RAM_SZ(512), .RAM_BW(8), .RAM_BS(4), .RAM_WS(WS_B)) dut_b (
    .ACLK(clk), .ARESETn(b_rst_n), .usr_req(b_req), .usr_gnt(b_gnt), .usr_we(b_we),
    .usr_addr(b_addr), .usr_be(b_be), .usr_wdata(b_wdata), .usr_rvalid(b_rvalid),
    .usr_rready(b_rready), .usr_rdata(b_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [8:0] a);
    return (int'(a) < SZ_A) ? model[a] : 32'h0;
  endfunction

  task automatic wr(input logic [8:0] a, input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
    chk("wr_gnt", {31'b0, gnt}, 32'd1);
    @(posedge clk);
    if (int'(a) < SZ_A)
      for (int i = 0; i < 4; i++)
        if (b[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
  endtask

  // hold = cycles rready stays low once rvalid is up
  task automatic rd(input logic [8:0] a, input int hold, input logic [31:0] exp);
    int n;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; be = 4'($urandom); wdata = $urandom;
    rready = (hold == 0);
    chk("rd_gnt", {31'b0, gnt}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req = 1'($urandom); we = 1'($urandom); addr = 9'($urandom);
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin
      chk("rd_wait_gnt", {31'b0, gnt}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk("rd_latency", n, WS_A);
    chk("rd_data", rdata, exp);
    chk("rd_resp_gnt", {31'b0, gnt}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, rvalid}, 32'd1);
      chk("bp_data", rdata, exp);
      chk("bp_gnt", {31'b0, gnt}, 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    chk("rd_done_valid", {31'b0, rvalid}, 32'd0);
    chk("rd_done_gnt", {31'b0, gnt}, 32'd1);
    req = 1'b0; rready = 1'b0;
  endtask

  initial begin
    int n;
    logic [8:0] a;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; rready = 1'b0;
    b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;
    b_rready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_valid", {31'b0, rvalid}, 32'd0);
    chk("rst_hold_data", rdata, 32'd0);
    rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    chk("rst_gnt", {31'b0, gnt}, 32'd1);
    chk("rst_valid", {31'b0, rvalid}, 32'd0);
    chk("rst_data", rdata, 32'd0);

    // read-after-write, byte lanes, backpressure
    wr(9'd5, 4'hF, 32'hDEAD_BEEF);
    rd(9'd5, 0, 32'hDEAD_BEEF);
    wr(9'd7, 4'hF, 32'h1122_3344);
    wr(9'd7, 4'b0101, 32'hAAAA_AAAA);
    rd(9'd7, 0, 32'h11AA_33AA);
    rd(9'd5, 10, 32'hDEAD_BEEF);

    // out of range and empty byte-enable writes
    wr(9'd510, 4'hF, 32'h1234_5678);
    rd(9'd510, 0, 32'h0);
    wr(9'd5, 4'h0, 32'hFFFF_FFFF);
    rd(9'd5, 1, 32'hDEAD_BEEF);
    rd(9'd7, 0, 32'h11AA_33AA);

    // fill the whole array so every in-range read has a defined answer
    for (int i = 0; i < SZ_A; i++) wr(9'(i), 4'hF, $urandom);
    @(negedge clk); req = 1'b0; we = 1'b1;

    for (int k = 0; k < 80; k++) begin
      a = 9'($urandom_range(0, 511));
      case ($urandom_range(0, 2))
        0: wr(a, 4'($urandom), $urandom);
        1: rd(a, $urandom_range(0, 3), expect_rd(a));
        default: begin
          @(negedge clk);
          req = 1'b0; we = 1'($urandom); addr = 9'($urandom); wdata = $urandom;
        end
      endcase
    end
    for (int k = 0; k < 20; k++) begin
      a = 9'($urandom_range(0, SZ_A - 1));
      rd(a, 0, expect_rd(a));
    end

    // second instance: reset while a read is waiting
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 9'd9; b_be = 4'hF; b_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    b_we = 1'b0; b_rready = 1'b1;
    chk("b_rd_gnt", {31'b0, b_gnt}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    b_req = 1'b0;
    chk("b_wait_valid", {31'b0, b_rvalid}, 32'd0);
    chk("b_wait_gnt", {31'b0, b_gnt}, 32'd0);
    #1 b_rst_n = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (b_rvalid !== 1'b0) n++;
    end
    b_rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (b_rvalid !== 1'b0) n++;
    end
    chk("b_no_resp", n, 0);
    chk("b_gnt_after_rst", {31'b0, b_gnt}, 32'd1);
    b_req = 1'b1; b_we = 1'b0; b_addr = 9'd9;
    @(posedge clk);
    @(negedge clk);
    b_req = 1'b0;
    n = 0;
    while (b_rvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_latency", n, WS_B);
    chk("b_data", b_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    chk("b_done_valid", {31'b0, b_rvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
